// File: rtl/evenp_checker.sv
// evenp_checker: receive-side checker for the 3-bit even-parity path.
// Flags every beat whose parity bit disagrees with a^b^c, keeps a saturating
// mismatch count, and on request runs an 8-vector sweep whose mismatch mask
// identifies the single stuck-at fault in the upstream parity generator.
module evenp_checker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       p,
  input  logic       sweep_start,
  output logic       err,
  output logic [7:0] err_count,
  output logic       busy,
  output logic       sweep_done,
  output logic [3:0] fault_code
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SWEEP    = 2'd1,
    CLASSIFY = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [3:0] CODE_SEQ_ERR  = 4'd14;
  localparam logic [3:0] CODE_UNKNOWN  = 4'd15;

  state_t     state, state_next;
  logic [2:0] idx;
  logic [7:0] mask;

  // Beat-level decode shared by the parity checker, FSM and sweep datapath.
  logic [2:0] word;
  logic       mis;
  logic       in_order;
  logic       sweep_beat;

  assign word       = {a, b, c};
  assign mis        = p ^ (a ^ b ^ c);
  assign in_order   = (word == idx);
  // A restart request outranks any beat arriving in the same cycle.
  assign sweep_beat = (state == SWEEP) && in_valid && !sweep_start;

  // Map a complete mismatch mask to the stuck-at fault that produces it.
  function automatic logic [3:0] classify(input logic [7:0] m);
    logic [3:0] code;
    case (m)
      8'h00:   code = 4'd0;
      8'hF0:   code = 4'd1;
      8'h0F:   code = 4'd2;
      8'hCC:   code = 4'd3;
      8'h33:   code = 4'd4;
      8'hAA:   code = 4'd5;
      8'h55:   code = 4'd6;
      8'h3C:   code = 4'd7;
      8'hC3:   code = 4'd8;
      8'h96:   code = 4'd9;
      8'h69:   code = 4'd10;
      default: code = CODE_UNKNOWN;
    endcase
    return code;
  endfunction

  // Parity check on every qualified beat, independent of the sweep FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      err_count <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values regardless of statement order.
      err <= in_valid & mis;
      if (in_valid && mis && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic; sweep_start restarts from any state.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    if (sweep_start) begin
      state_next = SWEEP;
    end else begin
      case (state)
        SWEEP: begin
          if (in_valid) begin
            if (!in_order)      state_next = DONE;
            else if (idx == 3'd7) state_next = CLASSIFY;
          end
        end
        CLASSIFY: state_next = DONE;
        default:  state_next = state;
      endcase
    end
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    busy       = 1'b0;
    sweep_done = 1'b0;
    case (state)
      SWEEP, CLASSIFY: busy       = 1'b1;
      DONE:            sweep_done = 1'b1;
      default: ;
    endcase
  end

  // Sweep datapath: vector index, mismatch mask and classification result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 3'd0;
      mask       <= 8'h00;
      fault_code <= 4'd0;
    end else if (sweep_start) begin
      idx  <= 3'd0;
      mask <= 8'h00;
    end else if (sweep_beat) begin
      if (in_order) begin
        mask[idx] <= mis;
        idx       <= idx + 3'd1;
      end else begin
        fault_code <= CODE_SEQ_ERR;
      end
    end else if (state == CLASSIFY) begin
      fault_code <= classify(mask);
    end
  end

endmodule

// File: tb/tb_evenp_checker.sv
// Directed bench for evenp_checker: expected err values are queued when each
// beat is driven and popped once the DUT has sampled it; a saturating count
// model tracks err_count, and sweep results are compared against known codes.
module tb_evenp_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       a, b, c, p;
  logic       sweep_start;
  logic       err;
  logic [7:0] err_count;
  logic       busy;
  logic       sweep_done;
  logic [3:0] fault_code;

  int         total = 0;
  int         bad   = 0;
  logic       sb_q[$];
  logic [7:0] exp_cnt = 8'd0;

  evenp_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .c          (c),
    .p          (p),
    .sweep_start(sweep_start),
    .err        (err),
    .err_count  (err_count),
    .busy       (busy),
    .sweep_done (sweep_done),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Parity bit emitted by the generator under a given fault model.
  function automatic logic gen_p(input int mode, input logic [2:0] abc);
    case (mode)
      1:       return abc[1] ^ abc[0];        // a stuck-at-0
      8:       return ~abc[0];                // w stuck-at-1
      10:      return 1'b1;                   // p stuck-at-1
      default: return abc[2] ^ abc[1] ^ abc[0];
    endcase
  endfunction

  // One clock of stimulus; inputs change 1 time unit after a rising edge.
  task automatic step(input logic v, input logic [2:0] abc, input logic pp, input logic st);
    logic exp_err;
    logic m;
    in_valid    = v;
    {a, b, c}   = abc;
    p           = pp;
    sweep_start = st;
    m = pp ^ abc[2] ^ abc[1] ^ abc[0];
    sb_q.push_back(v & m);
    @(posedge clk);
    #1;
    exp_err = sb_q.pop_front();
    if (v && m && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    check("err", {7'd0, err}, {7'd0, exp_err});
    check("err_count", err_count, exp_cnt);
    in_valid    = 1'b0;
    sweep_start = 1'b0;
  endtask

  task automatic idle_step();
    step(1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic start_sweep();
    step(1'b0, 3'd0, 1'b0, 1'b1);
    check("busy_after_start", {7'd0, busy}, 8'd1);
    check("done_after_start", {7'd0, sweep_done}, 8'd0);
  endtask

  // Eight in-order beats under a fault model, then the classification result.
  task automatic sweep_body(input int mode, input logic [3:0] code, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) idle_step();
      step(1'b1, 3'(i), gen_p(mode, 3'(i)), 1'b0);
      check("busy_in_sweep", {7'd0, busy}, 8'd1);
    end
    check("done_in_classify", {7'd0, sweep_done}, 8'd0);
    idle_step();
    check("sweep_done", {7'd0, sweep_done}, 8'd1);
    check("busy_when_done", {7'd0, busy}, 8'd0);
    check("fault_code", {4'd0, fault_code}, {4'd0, code});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb_q.delete();
    exp_cnt = 8'd0;
    #2;
    check("rst_err", {7'd0, err}, 8'd0);
    check("rst_err_count", err_count, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_sweep_done", {7'd0, sweep_done}, 8'd0);
    check("rst_fault_code", {4'd0, fault_code}, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0; p = 1'b0;
    sweep_start = 1'b0;
    #1;
    do_reset();
    idle_step();

    // Fault-free generator.
    start_sweep();
    sweep_body(0, 4'd0, 1'b0);
    check("clean_count", err_count, 8'd0);

    // a stuck-at-0: mismatches on vectors 4..7; restart from DONE.
    start_sweep();
    sweep_body(1, 4'd1, 1'b0);
    check("a_sa0_count", err_count, 8'd4);

    // w stuck-at-1 then p stuck-at-1 from a fresh count.
    do_reset();
    start_sweep();
    sweep_body(8, 4'd8, 1'b0);
    start_sweep();
    sweep_body(10, 4'd10, 1'b0);
    check("p_sa1_count", err_count, 8'd8);

    // Sequence error on the third beat.
    start_sweep();
    step(1'b1, 3'd0, 1'b0, 1'b0);
    step(1'b1, 3'd1, 1'b1, 1'b0);
    step(1'b1, 3'd3, 1'b0, 1'b0);
    check("seq_done", {7'd0, sweep_done}, 8'd1);
    check("seq_code", {4'd0, fault_code}, 8'd14);
    check("seq_busy", {7'd0, busy}, 8'd0);

    // Faulty beats with stalls, restart after five, then a clean sweep.
    start_sweep();
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) idle_step();
      step(1'b1, 3'(i), gen_p(10, 3'(i)), 1'b0);
    end
    start_sweep();
    sweep_body(0, 4'd0, 1'b1);

    // Restart coinciding with the 8th beat: the beat is not counted.
    start_sweep();
    for (int i = 0; i < 7; i++) step(1'b1, 3'(i), gen_p(10, 3'(i)), 1'b0);
    step(1'b1, 3'd7, gen_p(10, 3'd7), 1'b1);
    check("restart_8th_busy", {7'd0, busy}, 8'd1);
    check("restart_8th_done", {7'd0, sweep_done}, 8'd0);
    sweep_body(0, 4'd0, 1'b0);

    // Reset mid-sweep with errors pending, then saturation.
    start_sweep();
    step(1'b1, 3'd0, 1'b1, 1'b0);
    step(1'b1, 3'd1, 1'b0, 1'b0);
    do_reset();
    idle_step();
    check("post_rst_busy", {7'd0, busy}, 8'd0);
    for (int i = 0; i < 300; i++) step(1'b1, 3'(i), ~gen_p(0, 3'(i)), 1'b0);
    check("saturated", err_count, 8'd255);
    idle_step();
    check("err_drops", {7'd0, err}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/evenp_checker.md
# evenp_checker

Receiving end of the 3-bit even-parity path. It takes data words `{a,b,c}` together with the parity bit `p` produced by the parity generator, and flags every beat whose parity is wrong. On request it runs an 8-vector sweep and classifies the generator's single stuck-at fault from the mismatch pattern. It sits downstream of the parity generator and replaces the manual, per-fault monitoring done in simulation with a synthesizable checker.

## Interface
- No parameters. Word width is fixed at 3 data bits plus 1 parity bit.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: qualifies `a`, `b`, `c`, `p` for one beat.
- `a`, `b`, `c` in 1 each: data word; `a` is the MSB of the vector index.
- `p` in 1: received parity bit; expected value is `a^b^c`.
- `sweep_start` in 1: single-cycle request to begin or restart a classification sweep.
- `err` out 1: registered one-cycle pulse; parity mismatch on the previous beat.
- `err_count` out 8: running count of mismatched beats, saturating.
- `busy` out 1: high while state is SWEEP or CLASSIFY.
- `sweep_done` out 1: high in DONE; `fault_code` is valid while it is high.
- `fault_code` out 4: result of the last sweep.

## Operation
- Parity check runs on every `in_valid` beat, in any state.
  - `mis = p ^ (a^b^c)`.
  - `err <= in_valid & mis`.
  - `err_count` increments on each mismatch, saturates at 255, and is cleared only by reset.
- FSM states: IDLE, SWEEP, CLASSIFY, DONE.
- IDLE, or DONE, with `sweep_start`:
  - Go to SWEEP; `idx <= 0`, `mask <= 8'h00`.
  - A beat presented in the same cycle is parity-checked but not counted toward the sweep.
- SWEEP, on each `in_valid` beat:
  - If `{a,b,c} != idx`: set `fault_code <= 14` (sequence error) and go directly to DONE.
  - Otherwise: `mask[idx] <= mis`, `idx <= idx+1`. After the beat with `idx==7`, go to CLASSIFY.
  - `in_valid` low stalls the sweep indefinitely; there is no timeout.
- `sweep_start` in SWEEP or CLASSIFY restarts the sweep: `idx` and `mask` are cleared and the state is SWEEP.
- CLASSIFY lasts one cycle. It registers `fault_code` from `mask`, then goes to DONE:

| mask | fault_code | fault |
|---|---|---|
| 00 | 0 | no fault |
| F0 | 1 | a stuck-at-0 |
| 0F | 2 | a stuck-at-1 |
| CC | 3 | b stuck-at-0 |
| 33 | 4 | b stuck-at-1 |
| AA | 5 | c stuck-at-0 |
| 55 | 6 | c stuck-at-1 |
| 3C | 7 | w=a^b stuck-at-0 |
| C3 | 8 | w stuck-at-1 |
| 96 | 9 | p stuck-at-0 |
| 69 | 10 | p stuck-at-1 |
| any other | 15 | unclassifiable |

- DONE holds `fault_code` and `sweep_done=1` until `sweep_start`. Parity checking continues in DONE.
- Reset values: `err=0`, `err_count=0`, `busy=0`, `sweep_done=0`, `fault_code=0`, state IDLE, `idx=0`, `mask=0`.
- Reset mid-sweep discards all sweep progress.

## Timing
- `err` and `err_count` update at the edge that samples the beat, so they are visible 1 cycle after the beat.
- Back-to-back mismatched beats give a continuous `err` high and `+1` per cycle on `err_count`.
- `busy` rises 1 cycle after `sweep_start` is sampled.
- Normal sweep completion:
  - The 8th beat is sampled at edge k, and the state is CLASSIFY after k.
  - `fault_code` is updated, `sweep_done` is 1 and `busy` is 0 after edge k+1.
  - Minimum sweep length is 1 + 8 + 1 cycles.
- Sequence error: `sweep_done=1` and `fault_code=14` after the edge that sampled the bad beat; CLASSIFY is skipped.
- `sweep_start` sampled in DONE: `sweep_done` falls and `busy` rises after the same edge.
- `sweep_start` together with the 8th beat: the restart wins; `mask` and `idx` are cleared, and the beat is parity-checked only.

## Test plan
- Fault-free generator:
  - Stimulus: `sweep_start`, then 8 beats `abc = 000..111` with `p = a^b^c`.
  - Required: `fault_code=0`, `sweep_done=1` 2 cycles after the last beat, `err` never high, `err_count=0`.
- a stuck-at-0 model:
  - Stimulus: `p = b^c`.
  - Required: `err` pulses on beats 4–7, `fault_code=1`, `err_count=4`.
- w stuck-at-1 model:
  - Stimulus: `p = ~c`.
  - Required: mask C3, `fault_code=8`. A following p stuck-at-1 sweep (`p = 1`) gives `fault_code=10` and `err_count=8`.
- Sequence error:
  - Stimulus: beats `000`, `001`, `011`.
  - Required: `fault_code=14` and `sweep_done=1` after the third beat; `busy=0`.
- Stalls and restart:
  - Stimulus: random `in_valid` gaps during a sweep, then `sweep_start` after 5 beats, then a full clean sweep.
  - Required: result `fault_code=0`; earlier beats are not counted.
- Reset and saturation:
  - Stimulus: assert `rst_n=0` mid-sweep.
  - Required: all outputs 0 immediately.
  - Stimulus: then 300 mismatched beats.
  - Required: `err_count` stops at 255.
